// File: rtl/alu_core.sv
// alu_core: single-cycle ALU with a combinational result/flag path and a
// registered copy of the result, the zero flag and a sticky overflow flag.
// There is no handshake: every clock edge accepts whatever operation is on
// the inputs, and the registered outputs always show the previous edge's op.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_SrcA,
  input  logic [WIDTH-1:0] i_SrcB,
  input  logic [2:0]       i_ALUCtrl,
  output logic [WIDTH-1:0] o_ALUResult,
  output logic             o_Zero,
  output logic             o_Overflow,
  output logic [WIDTH-1:0] o_ALUResultQ,
  output logic             o_ZeroQ,
  output logic             o_OvfSticky
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;

  // Shared adder/subtractor and their two's-complement overflow terms.
  always_comb begin
    sum     = i_SrcA + i_SrcB;
    diff    = i_SrcA + ~i_SrcB + WIDTH'(1);
    add_ovf = (i_SrcA[WIDTH-1] == i_SrcB[WIDTH-1]) &&
              (sum[WIDTH-1] != i_SrcA[WIDTH-1]);
    sub_ovf = (i_SrcA[WIDTH-1] != i_SrcB[WIDTH-1]) &&
              (diff[WIDTH-1] != i_SrcA[WIDTH-1]);
    // Signed less-than stays correct when A-B overflows.
    slt_bit = diff[WIDTH-1] ^ sub_ovf;
  end

  // Operation select; invalid codes yield a zero result and no overflow.
  always_comb begin
    o_ALUResult = '0;
    o_Overflow  = 1'b0;
    case (i_ALUCtrl)
      OP_ADD: begin
        o_ALUResult = sum;
        o_Overflow  = add_ovf;
      end
      OP_SUB: begin
        o_ALUResult = diff;
        o_Overflow  = sub_ovf;
      end
      OP_AND: o_ALUResult = i_SrcA & i_SrcB;
      OP_OR:  o_ALUResult = i_SrcA | i_SrcB;
      OP_SLT: o_ALUResult = {{(WIDTH-1){1'b0}}, slt_bit};
      default: begin
        o_ALUResult = '0;
        o_Overflow  = 1'b0;
      end
    endcase
    o_Zero = (o_ALUResult == '0);
  end

  // Registered copies; reset wins over both sampling and the sticky set.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_ALUResultQ <= '0;
      o_ZeroQ      <= 1'b0;
      o_OvfSticky  <= 1'b0;
    end else begin
      o_ALUResultQ <= o_ALUResult;
      o_ZeroQ      <= o_Zero;
      o_OvfSticky  <= o_OvfSticky | o_Overflow;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vector table, hand-written registered-path sequences
// and randomized operations checked against an arithmetic reference model.
module tb_alu_core;

  localparam int W = 32;

  logic         i_Clk;
  logic         i_Rst;
  logic [W-1:0] i_SrcA;
  logic [W-1:0] i_SrcB;
  logic [2:0]   i_ALUCtrl;
  logic [W-1:0] o_ALUResult;
  logic         o_Zero;
  logic         o_Overflow;
  logic [W-1:0] o_ALUResultQ;
  logic         o_ZeroQ;
  logic         o_OvfSticky;

  alu_core #(.WIDTH(W)) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_SrcA      (i_SrcA),
    .i_SrcB      (i_SrcB),
    .i_ALUCtrl   (i_ALUCtrl),
    .o_ALUResult (o_ALUResult),
    .o_Zero      (o_Zero),
    .o_Overflow  (o_Overflow),
    .o_ALUResultQ(o_ALUResultQ),
    .o_ZeroQ     (o_ZeroQ),
    .o_OvfSticky (o_OvfSticky)
  );

  // clock / reset block
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int checks   = 0;
  int failures = 0;

  // scoreboard: expected registered values for ops already driven
  logic [W-1:0] exp_q[$];
  logic         exp_zq[$];
  logic         exp_sq[$];
  logic         sticky_m;

  typedef struct {
    logic [2:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions, using 64-bit signed math.
  function automatic void ref_alu(input logic [2:0] c, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic z, output logic o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    o = 1'b0;
    case (c)
      3'b000: begin
        s = sa + sb;
        r = s[W-1:0];
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b001: begin
        s = sa - sb;
        r = s[W-1:0];
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    z = (r == 0);
  endfunction

  // Check registered outputs for the op driven one edge earlier.
  task automatic check_pending();
    if (exp_q.size() > 0) begin
      chk("result_q", o_ALUResultQ, exp_q.pop_front());
      chk("zero_q", W'(o_ZeroQ), W'(exp_zq.pop_front()));
      chk("ovf_sticky", W'(o_OvfSticky), W'(exp_sq.pop_front()));
    end
  endtask

  // driver: one op per cycle, comb checked #1 after driving on the negedge
  task automatic do_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ez, input logic eo, input string tag);
    @(negedge i_Clk);
    check_pending();
    i_ALUCtrl = c;
    i_SrcA    = a;
    i_SrcB    = b;
    #1;
    chk({tag, "_result"}, o_ALUResult, er);
    chk({tag, "_zero"}, W'(o_Zero), W'(ez));
    chk({tag, "_ovf"}, W'(o_Overflow), W'(eo));
    sticky_m = sticky_m | eo;
    exp_q.push_back(er);
    exp_zq.push_back(ez);
    exp_sq.push_back(sticky_m);
  endtask

  task automatic model_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
    logic [W-1:0] r;
    logic z, o;
    ref_alu(c, a, b, r, z, o);
    do_op(c, a, b, r, z, o, tag);
  endtask

  // Reset for one edge while an overflowing ADD is on the inputs.
  task automatic pulse_reset();
    @(negedge i_Clk);
    check_pending();
    i_Rst = 1'b1;
    i_ALUCtrl = 3'b000;
    i_SrcA = 32'h7FFFFFFE;
    i_SrcB = 32'h7FFFFFFF;
    #1;
    chk("rst_comb_result", o_ALUResult, 32'hFFFFFFFD);
    chk("rst_comb_ovf", W'(o_Overflow), 32'd1);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    chk("rst_result_q", o_ALUResultQ, 32'd0);
    chk("rst_zero_q", W'(o_ZeroQ), 32'd0);
    chk("rst_sticky", W'(o_OvfSticky), 32'd0);
    sticky_m = 1'b0;
    i_ALUCtrl = 3'b010;
    i_SrcA = '0;
    i_SrcB = '0;
  endtask

  initial begin
    i_Rst = 1'b1;
    i_ALUCtrl = 3'b000;
    i_SrcA = '0;
    i_SrcB = '0;
    sticky_m = 1'b0;

    vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'b000, 32'h00000010, 32'h00000005, 32'h00000015, 1'b0, 1'b0});
    vecs.push_back('{3'b001, 32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0});
    vecs.push_back('{3'b010, 32'h0000000F, 32'h0000000A, 32'h0000000A, 1'b0, 1'b0});
    vecs.push_back('{3'b011, 32'h0000FF00, 32'h000000FF, 32'h0000FFFF, 1'b0, 1'b0});
    vecs.push_back('{3'b101, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'b101, 32'h7FFFFFFE, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'b101, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{3'b001, 32'h7FFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'b000, 32'h7FFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1});

    // reset state
    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk);
    chk("init_result_q", o_ALUResultQ, 32'd0);
    chk("init_zero_q", W'(o_ZeroQ), 32'd0);
    chk("init_sticky", W'(o_OvfSticky), 32'd0);
    i_Rst = 1'b0;

    // directed vector table
    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero, vecs[i].ovf,
            $sformatf("vec%0d", i));
    pulse_reset();
    exp_q.delete(); exp_zq.delete(); exp_sq.delete();

    // sticky sequence: overflow then quiet ops, then reset clears everything
    do_op(3'b000, 32'h7FFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, "seq_add_ovf");
    do_op(3'b010, 32'h0000000F, 32'h0000000A, 32'h0000000A, 1'b0, 1'b0, "seq_and");
    do_op(3'b011, 32'h0000FF00, 32'h000000FF, 32'h0000FFFF, 1'b0, 1'b0, "seq_or");
    @(negedge i_Clk);
    check_pending();
    chk("seq_sticky_held", W'(o_OvfSticky), 32'd1);
    pulse_reset();
    exp_q.delete(); exp_zq.delete(); exp_sq.delete();

    // randomized ops with biased operands to hit sign boundaries
    for (int i = 0; i < 300; i++) begin
      logic [2:0] c;
      logic [W-1:0] a, b;
      c = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: a = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
        1: b = 32'h80000000 + 32'($urandom_range(0, 3));
        2: b = a;
        default: ;
      endcase
      model_op(c, a, b, "rnd");
      if ($urandom_range(0, 60) == 0) begin
        pulse_reset();
        exp_q.delete(); exp_zq.delete(); exp_sq.delete();
      end
    end
    @(negedge i_Clk);
    check_pending();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
